// File: rtl/signed_mbyte_add_seq.sv
// Byte-serial signed adder: ripples one carry register across NBYTES bytes.
// Optional SIGNED_ADD_SATURATE_EN clamps the final sum on signed overflow.
module signed_mbyte_add_seq #(
    parameter int NBYTES = 4,
    parameter int W      = 8 * NBYTES
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         overflow,
    output logic         busy
);

    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADD  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    state;
    logic [W-1:0]  a_reg;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  sum_q;
    logic          carry;
    logic          cout_q;
    logic          ovf_q;
    logic [IW-1:0] idx;

    logic [IW+2:0] base;
    logic [7:0]    a_byte;
    logic [7:0]    b_byte;
    logic [8:0]    byte_sum;
    logic          ovf_now;

    always_comb begin
        base     = {idx, 3'b000};
        a_byte   = a_reg[base +: 8];
        b_byte   = b_reg[base +: 8];
        byte_sum = {1'b0, a_byte} + {1'b0, b_byte} + {8'b0, carry};
        // Signs of the full operands against the raw top-byte sum bit
        ovf_now  = (a_reg[W-1] & b_reg[W-1] & ~byte_sum[7])
                 | (~a_reg[W-1] & ~b_reg[W-1] & byte_sum[7]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            a_reg  <= '0;
            b_reg  <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        a_reg <= a;
                        b_reg <= b;
                        carry <= cin;
                        idx   <= '0;
                        state <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum_q[base +: 8] <= byte_sum[7:0];
                    carry            <= byte_sum[8];
                    idx              <= idx + IW'(1);
                    if (idx == LAST) begin
                        cout_q <= byte_sum[8];
                        ovf_q  <= ovf_now;
                        state  <= S_DONE;
`ifdef SIGNED_ADD_SATURATE_EN
                        if (ovf_now) begin
                            sum_q <= a_reg[W-1] ? {1'b1, {(W-1){1'b0}}}
                                                : {1'b0, {(W-1){1'b1}}};
                        end
`endif
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_signed_mbyte_add_seq.sv
// Bench for signed_mbyte_add_seq: queued reference results checked on handoff.
// Follows SIGNED_ADD_SATURATE_EN the same way the design does.
module tb_signed_mbyte_add_seq;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         overflow;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } res_t;

    res_t q[$];
    int checks = 0;
    int errors = 0;

    signed_mbyte_add_seq #(.NBYTES(NBYTES)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] x,
                                   input logic [W-1:0] y,
                                   input logic ci);
        res_t r;
        logic [W:0] u;
        u = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
        r.sum  = u[W-1:0];
        r.cout = u[W];
        r.ovf  = (x[W-1] == y[W-1]) && (u[W-1] != x[W-1]);
`ifdef SIGNED_ADD_SATURATE_EN
        if (r.ovf)
            r.sum = x[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
`endif
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic ci, input int stall);
        res_t e;
        int n;
        chk("pre_in_ready", in_ready, 1);
        in_valid  = 1'b1;
        a         = x;
        b         = y;
        cin       = ci;
        out_ready = 1'b0;
        tick();
        q.push_back(model(x, y, ci));
        in_valid = 1'b0;
        chk("busy_add", busy, 1);
        // n counts edges from the accepting edge inclusive
        n = 1;
        while (!out_valid && n < 50) begin
            tick();
            n++;
        end
        chk("latency", n, NBYTES + 1);
        if (stall > 0) begin
            in_valid = 1'b1;
            a        = ~x;
            b        = ~y;
            cin      = ~ci;
            for (int i = 0; i < stall; i++) begin
                tick();
                chk("stall_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
            end
            in_valid = 1'b0;
        end
        e = q.pop_front();
        chk("sum", sum, e.sum);
        chk("cout", cout, e.cout);
        chk("overflow", overflow, e.ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_out_valid", out_valid, 0);
        chk("post_in_ready", in_ready, 1);
    endtask

    initial begin
        int seen;
        reset     = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", overflow, 0);

        run_op(32'h0000_0001, 32'h0000_00FF, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0);
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        run_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 0);
        run_op(32'h1234_5678, 32'h0FED_CBA9, 1'b1, 5);
        run_op(32'h8000_0001, 32'hFFFF_FFFF, 1'b0, 0);
        for (int i = 0; i < 6; i++)
            run_op($urandom, $urandom, 1'($urandom_range(1)), i % 3);

        // Reset during the second ADD cycle discards the operation
        in_valid = 1'b1;
        a        = 32'h7FFF_FFFF;
        b        = 32'h7FFF_FFFF;
        cin      = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_in_ready", in_ready, 1);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_busy", busy, 0);
        chk("mid_sum", sum, 0);
        chk("mid_cout", cout, 0);
        chk("mid_ovf", overflow, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) seen++;
        end
        chk("mid_no_result", seen, 0);

        // Reset wins over a same-cycle operand offer
        reset    = 1'b1;
        in_valid = 1'b1;
        tick();
        reset    = 1'b0;
        in_valid = 1'b0;
        chk("rst_vs_valid", in_ready, 1);
        tick();
        chk("rst_vs_valid_busy", busy, 0);

        run_op(32'h0000_00FF, 32'h0000_0001, 1'b1, 0);
        chk("queue_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
